// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter that feeds one shared UART transmitter port.
// Each requester has a small FIFO. A round-robin scheduler moves one byte per completed frame.

module uart_tx_arbiter_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic [7:0] i_dat,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                overflow;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign o_empty    = (wr_ptr == rd_ptr);
  assign o_full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign o_head     = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign o_overflow = overflow;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      // Full is taken from the registered pointers, so a pop in this cycle frees no slot.
      if (i_push) begin
        if (o_full) overflow <= 1'b1;
        else        wr_ptr   <= wr_ptr + PTR_ONE;
      end
      if (i_pop && !o_empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) mem[wr_ptr[DEPTH_LOG2-1:0]] <= i_dat;
  end
endmodule

module uart_tx_arbiter #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_dat_a,
  input  logic       i_we_a,
  input  logic       i_cyc_a,
  output logic [7:0] o_dat_a,
  input  logic [7:0] i_dat_b,
  input  logic       i_we_b,
  input  logic       i_cyc_b,
  output logic [7:0] o_dat_b,
  output logic [7:0] o_tx_dat,
  output logic       o_tx_we,
  output logic       o_tx_cyc,
  input  logic [7:0] i_tx_stat,
  output logic       o_busy,
  output logic       o_gnt
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  logic [NUM_REQ-1:0]      push, pop, full, empty, ovf;
  logic [NUM_REQ-1:0][7:0] din, head;

  state_t     state, state_nxt;
  logic       gnt, sel, start;
  logic [7:0] tx_dat;
  logic       tx_active;
  logic       unused_stat;

  assign push = {i_cyc_b & i_we_b, i_cyc_a & i_we_a};
  assign din  = {i_dat_b, i_dat_a};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    uart_tx_arbiter_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_push     (push[g]),
      .i_dat      (din[g]),
      .i_pop      (pop[g]),
      .o_head     (head[g]),
      .o_full     (full[g]),
      .o_empty    (empty[g]),
      .o_overflow (ovf[g])
    );
  end

  assign tx_active   = i_tx_stat[0];
  assign unused_stat = ^i_tx_stat[7:1];

  always_comb begin
    state_nxt = state;
    pop       = '0;
    sel       = gnt;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (!(&empty) && !tx_active) begin
          start = 1'b1;
          // On a tie the requester that did not win last time goes next.
          if (empty[0])      sel = 1'b1;
          else if (empty[1]) sel = 1'b0;
          else               sel = ~gnt;
          pop[sel]  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:      state_nxt = WAIT_START;
      // The transmitter raises active a couple of cycles after the write; sit here until it does.
      WAIT_START: if (tx_active)  state_nxt = WAIT_DONE;
      WAIT_DONE:  if (!tx_active) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      gnt    <= 1'b1;
      tx_dat <= 8'h00;
    end else begin
      state <= state_nxt;
      if (start) begin
        gnt    <= sel;
        tx_dat <= head[sel];
      end
    end
  end

  assign o_tx_dat = tx_dat;
  assign o_tx_we  = (state == ISSUE);
  assign o_tx_cyc = (state == ISSUE);
  assign o_busy   = (state != IDLE);
  assign o_gnt    = gnt;
  assign o_dat_a  = {5'b0, ovf[0], empty[0], full[0]};
  assign o_dat_b  = {5'b0, ovf[1], empty[1], full[1]};
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench: stimulus queues the expected {grant, byte} pairs, and a monitor checks each transmitter write.
// A stub transmitter raises active 2 cycles after a write and holds it high for a 10-cycle frame.

module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dat_a, dat_b, st_a, st_b, tx_dat, tx_stat;
  logic       we_a, cyc_a, we_b, cyc_b, tx_we, tx_cyc, busy, gnt;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  logic act, pend, hold, prev_we;
  int   frm;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DEPTH_LOG2(2)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_dat_a(dat_a), .i_we_a(we_a), .i_cyc_a(cyc_a), .o_dat_a(st_a),
    .i_dat_b(dat_b), .i_we_b(we_b), .i_cyc_b(cyc_b), .o_dat_b(st_b),
    .o_tx_dat(tx_dat), .o_tx_we(tx_we), .o_tx_cyc(tx_cyc),
    .i_tx_stat(tx_stat), .o_busy(busy), .o_gnt(gnt)
  );

  assign tx_stat = {7'b0, act | hold};

  // Stub transmitter, reset together with the DUT.
  always @(posedge clk) begin
    if (rst) begin
      act <= 1'b0; pend <= 1'b0; frm <= 0;
    end else begin
      if (pend) begin
        pend <= 1'b0; act <= 1'b1; frm <= 9;
      end else if (act) begin
        if (frm == 0) act <= 1'b0;
        else          frm <= frm - 1;
      end
      if (tx_we && tx_cyc) pend <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
    end
  endtask

  // Monitor: every transmitter write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst) prev_we <= 1'b0;
    else begin
      if (tx_we) begin
        chk("tx_cyc_with_we", {31'b0, tx_cyc}, 32'd1);
        chk("single_cycle_write", {31'b0, prev_we}, 32'd0);
        chk("xmtr_idle_at_write", {30'b0, pend, act}, 32'd0);
        if (exp_q.size() == 0) chk("unexpected_write", {23'b0, gnt, tx_dat}, 32'h1ff);
        else chk("tx_byte_gnt", {23'b0, gnt, tx_dat}, {23'b0, exp_q.pop_front()});
      end
      prev_we <= tx_we;
    end
  end

  task automatic cyc(input logic ea, input logic [7:0] da, input logic eb, input logic [7:0] db);
    cyc_a = ea; we_a = ea; dat_a = da;
    cyc_b = eb; we_b = eb; dat_b = db;
    @(negedge clk);
    cyc_a = 0; we_a = 0; cyc_b = 0; we_b = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin @(negedge clk); n++; end
    chk(name, exp_q.size(), 0);
    chk({name, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_act(input logic lvl);
    int n = 0;
    while (act !== lvl && n < 50) begin @(negedge clk); n++; end
    chk("wait_active_level", {31'b0, act}, {31'b0, lvl});
  endtask

  task automatic wait_we();
    int n = 0;
    while (!tx_we && n < 20) begin @(negedge clk); n++; end
    chk("write_seen", {31'b0, tx_we}, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1; hold = 0;
    cyc_a = 0; we_a = 0; dat_a = 0; cyc_b = 0; we_b = 0; dat_b = 0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_st_a", st_a, 32'h02);
    chk("rst_st_b", st_b, 32'h02);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_gnt", {31'b0, gnt}, 32'd1);
    chk("rst_tx_we", {30'b0, tx_we, tx_cyc}, 32'd0);
    chk("rst_tx_dat", tx_dat, 32'h00);

    // Single byte from A
    exp_q.push_back({1'b0, 8'h41});
    cyc(1, 8'h41, 0, 8'h00);
    wait_we();
    chk("t1_st_a_after_pop", st_a, 32'h02);
    chk("t1_busy_in_issue", {31'b0, busy}, 32'd1);
    wait_act(1'b1);
    wait_act(1'b0);
    chk("t1_busy_until_fall", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_idle_after_fall", {31'b0, busy}, 32'd0);
    drain("t1_drain");

    // Simultaneous A/B traffic alternates starting with A
    do_reset();
    exp_q.push_back({1'b0, 8'hA0}); exp_q.push_back({1'b1, 8'hB0});
    exp_q.push_back({1'b0, 8'hA1}); exp_q.push_back({1'b1, 8'hB1});
    cyc(1, 8'hA0, 1, 8'hB0);
    cyc(1, 8'hA1, 1, 8'hB1);
    drain("t2_drain");

    // Overflow while the transmitter is held busy
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h10 + 8'(i)});
    for (int i = 0; i < 4; i++) cyc(1, 8'h10 + 8'(i), 0, 8'h00);
    chk("t3_full_after_4", st_a, 32'h01);
    cyc(1, 8'h14, 0, 8'h00);
    chk("t3_overflow_full", st_a, 32'h05);
    chk("t3_no_write_while_held", {31'b0, busy}, 32'd0);
    hold = 1'b0;
    drain("t3_drain");
    chk("t3_overflow_sticky", st_a, 32'h06);

    // Reset during WAIT_DONE with bytes queued
    do_reset();
    exp_q.push_back({1'b0, 8'h20});
    for (int i = 0; i < 6; i++) cyc(1, 8'h20 + 8'(i), 0, 8'h00);
    chk("t5_overflow_set", st_a, 32'h05);
    wait_act(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy_after_rst", {31'b0, busy}, 32'd0);
    chk("t5_st_a_after_rst", st_a, 32'h02);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_still_empty", st_a, 32'h02);
    chk("t5_queue_consumed", exp_q.size(), 0);

    // B pushed during A's frame goes out on the first IDLE after active falls
    do_reset();
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b1, 8'hB7});
    cyc(1, 8'h55, 0, 8'h00);
    wait_act(1'b1);
    @(negedge clk);
    cyc(0, 8'h00, 1, 8'hB7);
    wait_act(1'b0);
    n = 0;
    while (!tx_we && n < 10) begin @(negedge clk); n++; end
    chk("t6_issue_latency", n, 2);
    chk("t6_gnt_b", {31'b0, gnt}, 32'd1);
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
